// File: rtl/text_overlay_gen.sv
// Multi-line text overlay: maps the current pixel onto a writable character/colour
// buffer, fetches the glyph row from an external synchronous font ROM and emits colour.
module text_overlay_gen #(
    parameter int NUM_LINES      = 3,
    parameter int CHARS_PER_LINE = 3,
    parameter int SCALE          = 3,
    parameter int X0             = 192,
    parameter int Y0             = 64,
    parameter int BLINK_FRAMES   = 30,
    localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
    localparam int CW = (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           pix_x,
    input  logic [9:0]           pix_y,
    input  logic                 video_on,
    input  logic                 frame_tick,
    input  logic                 wr_en,
    input  logic [LW-1:0]        wr_line,
    input  logic [CW-1:0]        wr_col,
    input  logic [6:0]           wr_char,
    input  logic [2:0]           wr_color,
    input  logic [NUM_LINES-1:0] blink_mask,
    output logic [10:0]          rom_addr,
    input  logic [7:0]           font_word,
    output logic [NUM_LINES-1:0] text_on,
    output logic [2:0]           text_rgb
);

    localparam int W     = 8 << SCALE;
    localparam int H     = 16 << SCALE;
    localparam int X_END = X0 + CHARS_PER_LINE * W;
    localparam int DEPTH = NUM_LINES * CHARS_PER_LINE;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [9:0]           r_buf [DEPTH];
    logic [CNT_W-1:0]     r_blink_cnt;
    logic                 r_blink_phase;

    logic [10:0]          w_x, w_y, w_dx, w_dy_sel;
    logic [10:0]          w_dy [NUM_LINES];
    logic [NUM_LINES-1:0] w_hit_raw, w_hit;
    logic [LW-1:0]        w_sel;
    logic [CW-1:0]        w_col;
    logic [3:0]           w_row;
    logic [2:0]           w_bit;
    logic [IW-1:0]        w_idx, w_wr_idx;
    logic [9:0]           w_cell;
    logic                 w_blank, w_wr_ok, w_font_bit;

    logic [2:0]           r_bit1, r_bit2, r_color1, r_color2;
    logic [NUM_LINES-1:0] r_hit1, r_hit2;
    logic                 r_blank1, r_blank2;

    assign w_x  = {1'b0, pix_x};
    assign w_y  = {1'b0, pix_y};
    assign w_dx = w_x - 11'(X0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            localparam int YT = Y0 + gi * H;
            assign w_dy[gi]      = w_y - 11'(YT);
            assign w_hit_raw[gi] = video_on && (w_x >= 11'(X0)) && (w_x < 11'(X_END))
                                   && (w_y >= 11'(YT)) && (w_y < 11'(YT + H));
        end
    endgenerate

    // Scan from the top index down so the lowest matching line is the one kept.
    always_comb begin
        w_hit    = '0;
        w_sel    = '0;
        w_dy_sel = '0;
        for (int l = NUM_LINES - 1; l >= 0; l--) begin
            if (w_hit_raw[l]) begin
                w_hit    = '0;
                w_hit[l] = 1'b1;
                w_sel    = LW'(l);
                w_dy_sel = w_dy[l];
            end
        end
    end

    assign w_col   = CW'(w_dx >> (SCALE + 3));
    assign w_row   = 4'(w_dy_sel >> SCALE);
    assign w_bit   = 3'(w_dx >> SCALE);
    assign w_idx   = IW'(32'(w_sel) * CHARS_PER_LINE + 32'(w_col));
    assign w_cell  = (|w_hit) ? r_buf[w_idx] : 10'h000;
    assign w_blank = (|(w_hit & blink_mask)) & ~r_blink_phase;

    assign w_wr_ok  = wr_en && (32'(wr_line) < NUM_LINES) && (32'(wr_col) < CHARS_PER_LINE);
    assign w_wr_idx = IW'(32'(wr_line) * CHARS_PER_LINE + 32'(wr_col));

    // Read is combinational into S1, so a same-edge write is seen from the next pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
        end else if (w_wr_ok) begin
            r_buf[w_wr_idx] <= {wr_color, wr_char};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (frame_tick) begin
            if (r_blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_font_bit = font_word[3'd7 - r_bit2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr <= '0;
            r_bit1   <= '0;
            r_hit1   <= '0;
            r_color1 <= '0;
            r_blank1 <= 1'b0;
            r_bit2   <= '0;
            r_hit2   <= '0;
            r_color2 <= '0;
            r_blank2 <= 1'b0;
            text_on  <= '0;
            text_rgb <= '0;
        end else begin
            rom_addr <= (|w_hit) ? {w_cell[6:0], w_row} : 11'h000;
            r_bit1   <= w_bit;
            r_hit1   <= w_hit;
            r_color1 <= w_cell[9:7];
            r_blank1 <= w_blank;
            r_bit2   <= r_bit1;
            r_hit2   <= r_hit1;
            r_color2 <= r_color1;
            r_blank2 <= r_blank1;
            text_on  <= r_hit2;
            text_rgb <= ((|r_hit2) && !r_blank2 && w_font_bit) ? r_color2 : 3'b000;
        end
    end

endmodule

// File: tb/tb_text_overlay_gen.sv
// Directed bench for text_overlay_gen with a synthetic registered font ROM.
module tb_text_overlay_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  pix_x = '0, pix_y = '0;
    logic        video_on = 1'b1, frame_tick = 1'b0, wr_en = 1'b0;
    logic [1:0]  wr_line = '0, wr_col = '0;
    logic [6:0]  wr_char = '0;
    logic [2:0]  wr_color = '0;
    logic [2:0]  blink_mask = '0;
    logic [10:0] rom_addr;
    logic [7:0]  font_word = '0;
    logic [2:0]  text_on, text_rgb;

    int checks = 0;
    int errors = 0;

    text_overlay_gen dut (
        .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
        .frame_tick(frame_tick), .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col),
        .wr_char(wr_char), .wr_color(wr_color), .blink_mask(blink_mask),
        .rom_addr(rom_addr), .font_word(font_word), .text_on(text_on), .text_rgb(text_rgb)
    );

    always #5 clk = ~clk;

    // Glyph row = {low nibble of char, row}; read latency of one clock.
    always @(posedge clk) font_word <= rom_addr[7:0];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic render(input int x, input int y, input logic vid);
        @(negedge clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
        video_on = vid;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic write_cell(input int line, input int col, input int ch, input int colr);
        @(negedge clk);
        wr_en = 1'b1;
        wr_line = 2'(line);
        wr_col = 2'(col);
        wr_char = 7'(ch);
        wr_color = 3'(colr);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic tick_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic expect_pix(input string name, input int x, input int y,
                              input logic [2:0] on_exp, input logic [2:0] rgb_exp);
        render(x, y, 1'b1);
        checks++;
        if (text_on !== on_exp) begin
            errors++;
            $display("FAIL %s text_on at (%0d,%0d): got %b expected %b", name, x, y, text_on, on_exp);
        end
        checks++;
        if (text_rgb !== rgb_exp) begin
            errors++;
            $display("FAIL %s text_rgb at (%0d,%0d): got %b expected %b", name, x, y, text_rgb, rgb_exp);
        end
    endtask

    task automatic test_reset();
        pix_x = 10'd200;
        pix_y = 10'd70;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (text_on !== 3'b000 || text_rgb !== 3'b000 || rom_addr !== 11'h000) begin
            errors++;
            $display("FAIL reset_hold: got on=%b rgb=%b addr=%h expected 000 000 000", text_on, text_rgb, rom_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        expect_pix("reset_blank", 200, 70, 3'b001, 3'b000);
        checks++;
        if (rom_addr !== 11'h000) begin
            errors++;
            $display("FAIL reset_blank_addr: got %h expected 000", rom_addr);
        end
        $display("test_reset done");
    endtask

    task automatic test_k_sweep();
        logic [2:0] on_e, rgb_e;
        logic [7:0] fw;
        int row, b;
        write_cell(0, 0, 'h4B, 3'b100);
        render(192, 64, 1'b1);
        checks++;
        if (rom_addr !== 11'h4B0) begin
            errors++;
            $display("FAIL k_rom_addr: got %h expected 4b0", rom_addr);
        end
        for (int y = 60; y <= 196; y += 8) begin
            for (int x = 188; x <= 260; x += 8) begin
                on_e = 3'b000;
                rgb_e = 3'b000;
                if (x >= 192 && x < 384) begin
                    if (y >= 64 && y < 192) on_e = 3'b001;
                    else if (y >= 192 && y < 320) on_e = 3'b010;
                end
                if (on_e == 3'b001 && x < 256) begin
                    row = (y - 64) >> 3;
                    b = (x - 192) >> 3;
                    fw = {4'hB, 4'(row)};
                    if (fw[7 - b]) rgb_e = 3'b100;
                end
                expect_pix("k_sweep", x, y, on_e, rgb_e);
            end
        end
        $display("test_k_sweep done");
    endtask

    task automatic test_latency();
        write_cell(1, 1, 'h41, 3'b001);
        render(0, 0, 1'b1);
        @(negedge clk);
        pix_x = 10'd256;
        pix_y = 10'd200;
        @(posedge clk);
        #1;
        checks++;
        if (rom_addr !== 11'h411) begin
            errors++;
            $display("FAIL lat_rom_addr: got %h expected 411", rom_addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (text_on !== 3'b000) begin
            errors++;
            $display("FAIL lat_early: got %b expected 000", text_on);
        end
        @(posedge clk);
        #1;
        checks++;
        if (text_on !== 3'b010 || text_rgb !== 3'b000) begin
            errors++;
            $display("FAIL lat_3clk: got on=%b rgb=%b expected 010 000", text_on, text_rgb);
        end
        expect_pix("lat_glyph", 280, 200, 3'b010, 3'b001);
        $display("test_latency done");
    endtask

    task automatic test_collision();
        render(0, 0, 1'b1);
        @(negedge clk);
        pix_x = 10'd256;
        pix_y = 10'd200;
        wr_en = 1'b1;
        wr_line = 2'd1;
        wr_col = 2'd1;
        wr_char = 7'h4D;
        wr_color = 3'b110;
        @(posedge clk);
        #1;
        checks++;
        if (rom_addr !== 11'h411) begin
            errors++;
            $display("FAIL coll_old_addr: got %h expected 411", rom_addr);
        end
        @(negedge clk);
        wr_en = 1'b0;
        pix_x = 10'd264;
        @(posedge clk);
        #1;
        checks++;
        if (rom_addr !== 11'h4D1) begin
            errors++;
            $display("FAIL coll_new_addr: got %h expected 4d1", rom_addr);
        end
        @(negedge clk);
        pix_x = 10'd0;
        pix_y = 10'd0;
        @(posedge clk);
        #1;
        checks++;
        if (text_on !== 3'b010 || text_rgb !== 3'b000) begin
            errors++;
            $display("FAIL coll_old_pix: got on=%b rgb=%b expected 010 000", text_on, text_rgb);
        end
        @(posedge clk);
        #1;
        checks++;
        if (text_on !== 3'b010 || text_rgb !== 3'b110) begin
            errors++;
            $display("FAIL coll_new_pix: got on=%b rgb=%b expected 010 110", text_on, text_rgb);
        end
        $display("test_collision done");
    endtask

    task automatic test_boundaries();
        expect_pix("bound_x383", 383, 64, 3'b001, 3'b000);
        expect_pix("bound_x384", 384, 64, 3'b000, 3'b000);
        expect_pix("bound_x191", 191, 64, 3'b000, 3'b000);
        expect_pix("bound_y63", 192, 63, 3'b000, 3'b000);
        expect_pix("bound_y447", 192, 447, 3'b100, 3'b000);
        expect_pix("bound_y448", 192, 448, 3'b000, 3'b000);
        render(192, 64, 1'b0);
        checks++;
        if (text_on !== 3'b000 || text_rgb !== 3'b000 || rom_addr !== 11'h000) begin
            errors++;
            $display("FAIL video_off: got on=%b rgb=%b addr=%h expected 000 000 000", text_on, text_rgb, rom_addr);
        end
        $display("test_boundaries done");
    endtask

    task automatic test_blink();
        write_cell(2, 0, 'h45, 3'b010);
        blink_mask = 3'b100;
        expect_pix("blink_start", 200, 320, 3'b100, 3'b010);
        tick_frames(29);
        expect_pix("blink_29", 200, 320, 3'b100, 3'b010);
        tick_frames(1);
        expect_pix("blink_off", 200, 320, 3'b100, 3'b000);
        expect_pix("blink_line0", 192, 64, 3'b001, 3'b100);
        expect_pix("blink_line1", 280, 200, 3'b010, 3'b110);
        tick_frames(29);
        expect_pix("blink_off_59", 200, 320, 3'b100, 3'b000);
        tick_frames(1);
        expect_pix("blink_on_again", 200, 320, 3'b100, 3'b010);
        $display("test_blink done");
    endtask

    task automatic test_reset_mid();
        expect_pix("mid_before", 192, 64, 3'b001, 3'b100);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (text_on !== 3'b000 || text_rgb !== 3'b000 || rom_addr !== 11'h000) begin
            errors++;
            $display("FAIL mid_reset: got on=%b rgb=%b addr=%h expected 000 000 000", text_on, text_rgb, rom_addr);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        expect_pix("mid_after", 192, 64, 3'b001, 3'b000);
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_k_sweep();
        test_latency();
        test_collision();
        test_boundaries();
        test_blink();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_overlay_gen.md
Name: text_overlay_gen

Overview:
- Parametrised successor to the fixed three-initials text generator.
- Renders NUM_LINES lines of CHARS_PER_LINE glyphs from a writable character/colour buffer instead of hard-coded codes.
- Supports power-of-two scaling, per-line blinking and a fully registered pipeline matched to the synchronous font ROM.
- Sits between the VGA sync generator (pix_x/pix_y/video_on/frame_tick) and the RGB output mux; the font_rom instance lives outside the block.

Parameters:
- NUM_LINES, 3, number of stacked text lines.
- CHARS_PER_LINE, 3, glyphs per line.
- SCALE, 3, log2 magnification; cell is (8<<SCALE) x (16<<SCALE) pixels.
- X0, 192, left pixel of every line.
- Y0, 64, top pixel of line 0.
- BLINK_FRAMES, 30, frame_tick count per blink half-period.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- pix_x  in  10  current pixel column.
- pix_y  in  10  current pixel row.
- video_on  in  1  visible-area flag, aligned with pix_x/pix_y.
- frame_tick  in  1  one-cycle pulse per frame.
- wr_en  in  1  buffer write strobe.
- wr_line  in  clog2(NUM_LINES)  target line.
- wr_col  in  clog2(CHARS_PER_LINE)  target column.
- wr_char  in  7  ASCII code.
- wr_color  in  3  glyph colour {R,G,B}.
- blink_mask  in  NUM_LINES  bit l=1 makes line l blink.
- rom_addr  out  11  {char,row} to font ROM; registered.
- font_word  in  8  font ROM data, valid one clock after rom_addr.
- text_on  out  NUM_LINES  one-hot: pixel lies inside line l's box.
- text_rgb  out  3  glyph colour or 3'b000 background.

Behaviour:
- Reset (reset=0, async) values:
  - rom_addr=0, text_on=0, text_rgb=0, all pipeline registers=0.
  - blink counter=0, blink_phase=1 (visible).
  - Every buffer cell = {color 3'b000, char 7'h00}.
- Geometry:
  - W=8<<SCALE, H=16<<SCALE.
  - Line l is hit when X0 <= pix_x < X0+CHARS_PER_LINE*W and Y0+l*H <= pix_y < Y0+(l+1)*H.
  - Boxes never overlap; if a parameter set makes them overlap, the lowest l wins.
  - dx=pix_x-X0, dy=pix_y-Y0-l*H.
  - col=dx>>(SCALE+3), row=(dy>>SCALE)[3:0], bit=(dx>>SCALE)[2:0].
  - Geometry arithmetic is 11 bits wide so no wrap occurs.
- Buffer:
  - NUM_LINES*CHARS_PER_LINE entries of 10 bits.
  - Written on a rising edge when wr_en=1.
  - Out-of-range wr_line/wr_col writes are ignored.
  - Same-cycle write and read of one cell: the read returns the old contents; the new value is visible from the next pixel.
- Pipeline, all registered:
  - S1 (edge after sampling): rom_addr={char,row}, or 11'h000 when no line is hit or video_on=0. Registers bit, line hit vector and colour.
  - S2 (ROM edge): font_word is valid; S1 side data is delayed one more stage.
  - S3: text_on=hit vector.
  - S3: text_rgb=colour if font_word[7-bit]=1 and the line is not blanked; else 3'b000.
  - Total latency from pix_x/pix_y to text_on/text_rgb is 3 clocks; the sync generator delays hsync/vsync to match.
- Blink:
  - The counter increments on frame_tick.
  - On the tick where counter==BLINK_FRAMES-1: counter<=0 and blink_phase toggles.
  - Line l is blanked when blink_mask[l]=1 and blink_phase=0. text_on[l] stays asserted while blanked.
  - blink_mask is sampled in S1.
- video_on=0 forces the hit vector to 0 in S1. After 3 clocks text_on=0 and text_rgb=0.
- Reset mid-frame: outputs clear immediately; the buffer returns to blanks; rendering resumes 3 clocks after release.

Test Plan (defaults):
- Reset: with reset=0, drive pix (200,70) → text_on=000 and text_rgb=000. After release, pixels render blank glyph 0x00 → text_rgb=000.
- Write line0 col0 'K' (0x4B, colour 100):
  - Sweep pix_y=64..191, pix_x=192..255 → text_on=001 exactly in that box.
  - rom_addr=0x4B0 at row 0.
  - text_rgb=100 only where the K glyph bit is set, 3 clocks after the pixel.
- Latency/addressing:
  - pix=(256,200) → rom_addr={col1 char of line1,4'h1} one clock later.
  - text_on=010 three clocks after the pixel.
- Write-collision: write line1 col1 'M' in the same cycle its cell is read → that pixel uses the old char; the next pixel uses 0x4D.
- Blink:
  - blink_mask=100, line2 'E' colour 010; pulse frame_tick 30 times.
  - Line2 text_rgb becomes 000 while text_on[2]=1; lines 0 and 1 are unaffected.
  - Visible again after 30 more ticks.
- Boundaries:
  - pix_x=383 is inside the box; pix_x=384 and pix_y=448 are outside (text_on=0).
  - video_on=0 inside a box gives text_on=0.
  - Reset asserted mid-line clears outputs within the same cycle.
